genetico_cfg_loader: RTL and testbench

Serial configuration loader for the evolvable combinational core: receives a chromosome bitstream one bit per handshake and assembles it in a shadow register. It range-checks every source select, then commits atomically to the active conf_les/conf_outs buses that drive the genetic circuit. The core never sees a partially loaded chromosome.

---
 rtl/genetico_pkg.sv | 49 ++++
 rtl/genetico_cfg_check.sv | 42 ++++
 rtl/genetico_cfg_loader.sv | 164 ++++++++++++++++
 tb/tb_genetico_cfg_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genetico_pkg.sv
// genetico_pkg
// Shared sizing, state encoding and gene layouts for the evolvable-core
// configuration path. Other blocks pull these in with
// import genetico_pkg::*.
//
// Contents:
//   N_LE, LE_W, N_OUT, OUT_W  chromosome geometry
//   N_SRC, CFG_W, LES_W       derived sizes
//   CNT_W                     frame bit-counter width
//   state_t                   loader FSM states
//   le_gene_t, out_sel_t      gene field layouts
//   sel_bad()                 source-select range rule
package genetico_pkg;

  localparam int N_LE  = 27;
  localparam int LE_W  = 15;
  localparam int N_OUT = 8;
  localparam int OUT_W = 6;

  // Selectable sources: chromosome inputs first, then every LE output.
  localparam int N_SRC = N_OUT + N_LE;
  localparam int LES_W = N_LE * LE_W;
  localparam int CFG_W = LES_W + N_OUT * OUT_W;
  localparam int CNT_W = $clog2(CFG_W);

  localparam logic [OUT_W-1:0] SRC_LIMIT = OUT_W'(N_SRC);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  typedef struct packed {
    logic [2:0]       func;
    logic [OUT_W-1:0] src_b;
    logic [OUT_W-1:0] src_a;
  } le_gene_t;

  typedef struct packed {
    logic [OUT_W-1:0] src;
  } out_sel_t;

  // A select is illegal when it points past the last existing source.
  function automatic logic sel_bad(input logic [OUT_W-1:0] sel);
    return sel >= SRC_LIMIT;
  endfunction

endpackage

// File: rtl/genetico_cfg_check.sv
// genetico_cfg_check
// Purely combinational range check of a complete chromosome vector.
// It is kept as a separate block so the evolution controller can reuse
// the same legality rule before proposing a candidate.
//
// Ports:
//   cfg_vec  in   CFG_W-bit chromosome {conf_outs, conf_les}
//   err      out  1 when any LE source or output select is >= N_SRC
module genetico_cfg_check
  import genetico_pkg::*;
(
  input  logic [CFG_W-1:0] cfg_vec,
  output logic             err
);

  le_gene_t          gene;
  out_sel_t          osel;
  // All eight function codes are legal, so the function fields are
  // collected here only so that every chromosome bit has a reader.
  logic [N_LE*3-1:0] unused_func;

  always_comb begin
    err         = 1'b0;
    gene        = '0;
    osel        = '0;
    unused_func = '0;
    for (int i = 0; i < N_LE; i++) begin
      gene = le_gene_t'(cfg_vec[i*LE_W +: LE_W]);
      unused_func[i*3 +: 3] = gene.func;
      if (sel_bad(gene.src_a) || sel_bad(gene.src_b)) begin
        err = 1'b1;
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      osel = out_sel_t'(cfg_vec[LES_W + i*OUT_W +: OUT_W]);
      if (sel_bad(osel.src)) begin
        err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/genetico_cfg_loader.sv
// genetico_cfg_loader
// Serial chromosome loader. Bits are shifted MSB-first into a shadow
// register, the complete frame is range-checked for one cycle, and only
// a legal frame is committed atomically to the active configuration.
// The genetic core therefore never sees a partially loaded chromosome.
//
// Optional build macro: CFG_READBACK_EN adds the sout port, which
// streams the previously active chromosome out while a new one loads.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse that begins or restarts a frame
//   sdata      in   serial chromosome bit
//   svalid     in   sdata qualifier
//   sready     out  a bit is accepted this cycle (SHIFT only)
//   conf_les   out  active LE genes
//   conf_outs  out  active output selects
//   cfg_done   out  one-cycle pulse on a successful commit
//   cfg_err    out  sticky: last frame failed the range check
//   busy       out  frame in progress
//   sout       out  readback bit for the next beat (CFG_READBACK_EN)
module genetico_cfg_loader
  import genetico_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sdata,
  input  logic                        svalid,
  output logic                        sready,
  output logic [N_LE-1:0][LE_W-1:0]   conf_les,
  output logic [N_OUT-1:0][OUT_W-1:0] conf_outs,
  output logic                        cfg_done,
  output logic                        cfg_err,
  output logic                        busy
`ifdef CFG_READBACK_EN
  ,
  output logic                        sout
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_W - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CFG_W-1:0] shadow_q;
  logic [CFG_W-1:0] active_q;
  logic             done_q;
  logic             err_q;
  logic             beat;
  logic             check_err;

  genetico_cfg_check u_check (
    .cfg_vec (shadow_q),
    .err     (check_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start in SHIFT takes priority over a beat, so the frame restarts
  // instead of advancing towards CHECK.
  always_comb begin
    state_d = state_q;
    sready  = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sready = 1'b1;
        if (!start && svalid && (cnt_q == LAST_CNT)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign beat = svalid && sready;

  // The counter saturates at the last bit index; the transition to CHECK
  // happens on that same beat, so it never needs to count further.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (start) begin
            cnt_q <= '0;
          end else if (beat) begin
            shadow_q <= {shadow_q[CFG_W-2:0], sdata};
            if (cnt_q != LAST_CNT) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (check_err) begin
            err_q <= 1'b1;
          end else begin
            active_q <= shadow_q;
            done_q   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign conf_les  = active_q[LES_W-1:0];
  assign conf_outs = active_q[CFG_W-1:LES_W];
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

`ifdef CFG_READBACK_EN
  logic [CFG_W-1:0] rb_q;

  // The readback copy is taken whenever a start is honoured, so after a
  // full frame the host has seen exactly the chromosome that was active
  // when this frame began.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q <= '0;
    end else if (start && (state_q != CHECK)) begin
      rb_q <= active_q;
    end else if (beat) begin
      rb_q <= {rb_q[CFG_W-2:0], 1'b0};
    end
  end

  assign sout = (state_q == SHIFT) ? rb_q[CFG_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_genetico_cfg_loader.sv
// tb_genetico_cfg_loader
// Self-checking bench for genetico_cfg_loader. A behavioural model keeps
// the received bits in a queue, decodes whole chromosomes by index
// arithmetic and applies the range rule; a negedge process compares the
// DUT against it every cycle. Literal checks pin key values.
// Build with +define+CFG_READBACK_EN to also check the sout stream.
module tb_genetico_cfg_loader;
  import genetico_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic sdata  = 1'b0;
  logic svalid = 1'b0;
  logic sready;
  logic cfg_done;
  logic cfg_err;
  logic busy;
  logic [N_LE-1:0][LE_W-1:0]   conf_les;
  logic [N_OUT-1:0][OUT_W-1:0] conf_outs;
`ifdef CFG_READBACK_EN
  logic sout;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  genetico_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sdata     (sdata),
    .svalid    (svalid),
    .sready    (sready),
    .conf_les  (conf_les),
    .conf_outs (conf_outs),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy)
`ifdef CFG_READBACK_EN
    ,
    .sout      (sout)
`endif
  );

  // ---------------- behavioural model ----------------
  logic [LE_W-1:0]  m_les   [N_LE];
  logic [OUT_W-1:0] m_outs  [N_OUT];
  logic [LE_W-1:0]  rb_les  [N_LE];
  logic [OUT_W-1:0] rb_outs [N_OUT];
  bit               m_loading;
  bit               m_deciding;
  bit               m_done;
  bit               m_done_nx;
  bit               m_err;
  bit               m_bits[$];
  bit               checks_on = 0;

  // Bit k of the transmitted stream (k = 0 is sent first) taken from either
  // the model's active chromosome or its readback snapshot.
  function automatic logic stream_bit(input int k, input bit from_rb);
    int idx;
    int pos;
    if (k < N_OUT * OUT_W) begin
      idx = N_OUT - 1 - k / OUT_W;
      pos = OUT_W - 1 - k % OUT_W;
      return from_rb ? rb_outs[idx][pos] : m_outs[idx][pos];
    end
    idx = N_LE - 1 - (k - N_OUT * OUT_W) / LE_W;
    pos = LE_W - 1 - (k - N_OUT * OUT_W) % LE_W;
    return from_rb ? rb_les[idx][pos] : m_les[idx][pos];
  endfunction

  task automatic model_decide();
    logic [LE_W-1:0]  d_les  [N_LE];
    logic [OUT_W-1:0] d_outs [N_OUT];
    int idx;
    int pos;
    bit ok;
    for (int k = 0; k < CFG_W; k++) begin
      if (k < N_OUT * OUT_W) begin
        idx = N_OUT - 1 - k / OUT_W;
        pos = OUT_W - 1 - k % OUT_W;
        d_outs[idx][pos] = m_bits[k];
      end else begin
        idx = N_LE - 1 - (k - N_OUT * OUT_W) / LE_W;
        pos = LE_W - 1 - (k - N_OUT * OUT_W) % LE_W;
        d_les[idx][pos] = m_bits[k];
      end
    end
    ok = 1;
    for (int i = 0; i < N_OUT; i++) if (int'(d_outs[i]) >= N_SRC) ok = 0;
    for (int i = 0; i < N_LE; i++) begin
      if (int'(d_les[i][5:0]) >= N_SRC) ok = 0;
      if (int'(d_les[i][11:6]) >= N_SRC) ok = 0;
    end
    if (ok) begin
      m_les     = d_les;
      m_outs    = d_outs;
      m_done_nx = 1;
    end else begin
      m_err = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LE; i++) begin m_les[i] = '0; rb_les[i] = '0; end
      for (int i = 0; i < N_OUT; i++) begin m_outs[i] = '0; rb_outs[i] = '0; end
      m_loading  = 0;
      m_deciding = 0;
      m_done     = 0;
      m_err      = 0;
      m_bits.delete();
    end else begin
      m_done_nx = 0;
      if (m_deciding) begin
        model_decide();
        m_deciding = 0;
      end else if (m_loading) begin
        if (start) begin
          m_bits.delete();
          rb_les  = m_les;
          rb_outs = m_outs;
        end else if (svalid) begin
          m_bits.push_back(sdata);
          if (m_bits.size() == CFG_W) begin
            m_loading  = 0;
            m_deciding = 1;
          end
        end
      end else if (start) begin
        m_loading = 1;
        m_err     = 0;
        m_bits.delete();
        rb_les  = m_les;
        rb_outs = m_outs;
      end
      m_done = m_done_nx;
    end
  end

  task automatic checkOutput(input string name, input logic [CFG_W-1:0] act,
                             input logic [CFG_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [N_LE-1:0][LE_W-1:0]   e_les;
  logic [N_OUT-1:0][OUT_W-1:0] e_outs;

  always @(negedge clk) begin
    if (checks_on && rst_n) begin
      for (int i = 0; i < N_LE; i++) e_les[i] = m_les[i];
      for (int i = 0; i < N_OUT; i++) e_outs[i] = m_outs[i];
      checkOutput("cmp conf_les", CFG_W'(conf_les), CFG_W'(e_les));
      checkOutput("cmp conf_outs", CFG_W'(conf_outs), CFG_W'(e_outs));
      checkOutput("cmp sready", CFG_W'(sready), CFG_W'(m_loading));
      checkOutput("cmp busy", CFG_W'(busy), CFG_W'(m_loading || m_deciding));
      checkOutput("cmp cfg_done", CFG_W'(cfg_done), CFG_W'(m_done));
      checkOutput("cmp cfg_err", CFG_W'(cfg_err), CFG_W'(m_err));
`ifdef CFG_READBACK_EN
      checkOutput("cmp sout", CFG_W'(sout),
                  CFG_W'(m_loading ? stream_bit(m_bits.size(), 1) : 1'b0));
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [CFG_W-1:0] fa;
  logic [CFG_W-1:0] fbad;
  logic [CFG_W-1:0] fc;
  logic [CFG_W-1:0] fg;
  logic [CFG_W-1:0] cap;

  task automatic applyStimulus(input logic st, input logic v, input logic d);
    start  = st;
    svalid = v;
    sdata  = d;
    @(posedge clk);
    #1;
  endtask

  // Sends bits first..last-1 of frame fv, optionally preceded by a start
  // pulse and optionally with random idle gaps between beats.
  task automatic send_frame(input logic [CFG_W-1:0] fv, input int first,
                            input int last, input bit pulse, input bit gaps);
    if (pulse) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = first; k < last; k++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
`ifdef CFG_READBACK_EN
      cap[CFG_W-1-k] = sout;
`endif
      applyStimulus(1'b0, 1'b1, fv[CFG_W-1-k]);
    end
    start  = 1'b0;
    svalid = 1'b0;
  endtask

  initial begin
    cap = '0;
    // Frame A: outputs 8+i, every LE func 3, B=2, A=1 -> 15'h3081.
    fa = '0;
    for (int i = 0; i < N_OUT; i++) fa[LES_W + i*OUT_W +: OUT_W] = OUT_W'(8 + i);
    for (int i = 0; i < N_LE; i++) fa[i*LE_W +: LE_W] = 15'h3081;
    fbad = fa;
    fbad[LES_W +: OUT_W] = 6'd35;
    fc = '0;
    for (int i = 0; i < N_OUT; i++) fc[LES_W + i*OUT_W +: OUT_W] = OUT_W'($urandom_range(0, 34));
    for (int i = 0; i < N_LE; i++)
      fc[i*LE_W +: LE_W] = {3'($urandom_range(0, 7)), 6'($urandom_range(0, 34)),
                            6'($urandom_range(0, 34))};
    fg = '0;
    for (int i = 0; i < CFG_W; i++) fg[i] = 1'($urandom_range(0, 1));

    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    checks_on = 1;

    // 1: reset state, beats in IDLE ignored
    checkOutput("reset conf_les", CFG_W'(conf_les), '0);
    checkOutput("reset conf_outs", CFG_W'(conf_outs), '0);
    checkOutput("reset busy", CFG_W'(busy), '0);
    checkOutput("reset sready", CFG_W'(sready), '0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle beats conf_les", CFG_W'(conf_les), '0);
    checkOutput("idle beats busy", CFG_W'(busy), '0);

    // 2: full frame, commit latency
    send_frame(fa, 0, CFG_W, 1, 0);
    checkOutput("T+1 cfg_done", CFG_W'(cfg_done), '0);
    checkOutput("T+1 busy", CFG_W'(busy), CFG_W'(1));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("T+2 cfg_done", CFG_W'(cfg_done), CFG_W'(1));
    checkOutput("T+2 busy", CFG_W'(busy), '0);
    checkOutput("A conf_outs[0]", CFG_W'(conf_outs[0]), CFG_W'(8));
    checkOutput("A conf_outs[7]", CFG_W'(conf_outs[7]), CFG_W'(15));
    checkOutput("A conf_les[0]", CFG_W'(conf_les[0]), CFG_W'(15'h3081));
    checkOutput("A conf_les[26]", CFG_W'(conf_les[26]), CFG_W'(15'h3081));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("done pulse width", CFG_W'(cfg_done), '0);

    // 3: out-of-range select rejected, config retained
    send_frame(fbad, 0, CFG_W, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bad cfg_err", CFG_W'(cfg_err), CFG_W'(1));
    checkOutput("bad cfg_done", CFG_W'(cfg_done), '0);
    checkOutput("bad retained", {conf_outs, conf_les}, fa);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start clears cfg_err", CFG_W'(cfg_err), '0);

    // 4: restart after 200 beats with random gaps
    send_frame(fg, 0, 200, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    send_frame(fc, 0, CFG_W, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restart commit", {conf_outs, conf_les}, fc);

    // 5: reset mid-frame clears the active config
    send_frame(fa, 0, 300, 1, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset conf", {conf_outs, conf_les}, '0);
    checkOutput("midreset busy", CFG_W'(busy), '0);
    checkOutput("midreset sready", CFG_W'(sready), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(fa, 0, CFG_W, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post-reset commit", {conf_outs, conf_les}, fa);

`ifdef CFG_READBACK_EN
    // 6: loading C streams out the previous chromosome A
    cap = '0;
    send_frame(fc, 0, CFG_W, 1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("readback stream", cap, fa);
    checkOutput("readback sout idle", CFG_W'(sout), '0);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
